// File: rtl/lsu_pkg.sv
// Shared types and helpers for the LSU memory initiator: access sizes, FSM states,
// alignment checks and word-address formation.
package lsu_pkg;

    localparam int unsigned LANE_BYTES = 4;
    localparam int unsigned WORD_W     = LANE_BYTES * 8;
    localparam int unsigned LSU_ADDR_W = 32;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } state_e;

    // Size encoding 3 is reported as a fault alongside genuine misalignment.
    function automatic logic is_misaligned(input size_e size, input logic [1:0] lane);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = lane[0];
            SZ_W:    bad = (lane != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [LSU_ADDR_W-1:0] word_align(input logic [LSU_ADDR_W-1:0] addr);
        return {addr[LSU_ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts and extends load data from a memory word, and
// merges sub-word store data into the word that was read back.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [WORD_W-1:0] word_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [1:0]        lane_i,
    input  size_e             size_i,
    input  logic              unsigned_i,
    output logic [WORD_W-1:0] rdata_o,
    output logic [WORD_W-1:0] merged_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[{lane_i, 3'b000} +: 8];
        half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];
        case (size_i)
            SZ_B:    rdata_o = unsigned_i ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            SZ_H:    rdata_o = unsigned_i ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: rdata_o = word_i;
        endcase
    end

    always_comb begin
        merged_o = word_i;
        case (size_i)
            SZ_B:    merged_o[{lane_i, 3'b000} +: 8]        = wdata_i[7:0];
            SZ_H:    merged_o[{lane_i[1], 4'b0000} +: 16]   = wdata_i[15:0];
            SZ_W:    merged_o                               = wdata_i;
            default: merged_o                               = word_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Core-side load/store initiator for a 32-bit word memory; sub-word stores are read-modify-write.
// Define LSU_WORD_STORE_BYPASS_EN to let aligned word stores skip the read phase.
module lsu_mem_initiator
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = LSU_ADDR_W,
    parameter int unsigned DATA_W = WORD_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_exception,
    output logic [ADDR_W-1:0] out_read_address,
    input  logic [DATA_W-1:0] in_read_data,
    input  logic              in_read_exception,
    output logic              out_write_enable,
    output logic [ADDR_W-1:0] out_write_address,
    output logic [DATA_W-1:0] out_write_data,
    input  logic              in_write_exception
);

    state_e            state_q, state_d;
    logic              store_q, store_d;
    size_e             size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] wword_q, wword_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              exc_q, exc_d;
    logic [DATA_W-1:0] ext_rdata;
    logic [DATA_W-1:0] merged_word;

    lsu_lane_align u_align (
        .word_i     (in_read_data),
        .wdata_i    (wdata_q),
        .lane_i     (addr_q[1:0]),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .rdata_o    (ext_rdata),
        .merged_o   (merged_word)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            store_q <= 1'b0;
            size_q  <= SZ_B;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wword_q <= '0;
            rdata_q <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            store_q <= store_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wword_q <= wword_d;
            rdata_q <= rdata_d;
            exc_q   <= exc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        store_d = store_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wword_d = wword_q;
        rdata_d = rdata_q;
        exc_d   = exc_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    store_d = req_store;
                    size_d  = size_e'(req_size);
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    exc_d   = 1'b0;
                    if (is_misaligned(size_e'(req_size), req_addr[1:0])) begin
                        exc_d   = 1'b1;
                        state_d = RESP;
                    end
`ifdef LSU_WORD_STORE_BYPASS_EN
                    else if (req_store && (size_e'(req_size) == SZ_W)) begin
                        wword_d = req_wdata;
                        state_d = WRITE;
                    end
`endif
                    else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                // A faulted read never reaches WRITE, so the memory word is left untouched.
                if (in_read_exception) begin
                    exc_d   = 1'b1;
                    state_d = RESP;
                end else if (store_q) begin
                    wword_d = merged_word;
                    state_d = WRITE;
                end else begin
                    rdata_d = ext_rdata;
                    state_d = RESP;
                end
            end
            WRITE: begin
                exc_d   = in_write_exception;
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready         = (state_q == IDLE);
        resp_valid        = (state_q == RESP);
        resp_rdata        = rdata_q;
        resp_exception    = exc_q;
        out_read_address  = word_align(addr_q);
        out_write_address = word_align(addr_q);
        out_write_data    = wword_q;
        out_write_enable  = (state_q == WRITE) && !RESET;
    end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed scoreboard bench for lsu_mem_initiator: stimulus queues expected responses and
// write strobes; independent monitors pop and compare them against the DUT.
module tb_lsu_mem_initiator;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_exception;
    logic [31:0] out_read_address;
    logic [31:0] in_read_data;
    logic        in_read_exception;
    logic        out_write_enable;
    logic [31:0] out_write_address;
    logic [31:0] out_write_data;
    logic        in_write_exception;

    logic        rd_fault = 1'b0;
    logic        wr_fault = 1'b0;
    logic [31:0] mem [0:255];
    int          cyc = 0;
    int          total = 0;
    int          passed = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        exc;
        int          lat;
        int          acc;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          lat;
        int          acc;
    } wr_t;

    resp_t exp_q[$];
    wr_t   wexp_q[$];
    resp_t cur;
    logic  in_resp = 1'b0;

    lsu_mem_initiator dut (
        .CLK                (CLK),
        .RESET              (RESET),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_store          (req_store),
        .req_size           (req_size),
        .req_unsigned       (req_unsigned),
        .req_addr           (req_addr),
        .req_wdata          (req_wdata),
        .resp_valid         (resp_valid),
        .resp_ready         (resp_ready),
        .resp_rdata         (resp_rdata),
        .resp_exception     (resp_exception),
        .out_read_address   (out_read_address),
        .in_read_data       (in_read_data),
        .in_read_exception  (in_read_exception),
        .out_write_enable   (out_write_enable),
        .out_write_address  (out_write_address),
        .out_write_data     (out_write_data),
        .in_write_exception (in_write_exception)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    assign in_read_data       = mem[out_read_address[9:2]];
    assign in_read_exception  = rd_fault;
    assign in_write_exception = wr_fault;

    // Faulted writes are dropped by the memory model.
    always @(posedge CLK)
        if (out_write_enable && !wr_fault) mem[out_write_address[9:2]] <= out_write_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    always @(negedge CLK) begin
        if (resp_valid) begin
            if (!in_resp) begin
                if (exp_q.size() == 0) begin
                    chk("resp_unexpected", 32'd1, 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    in_resp = 1'b1;
                    chk("resp_latency", 32'(cyc - cur.acc), 32'(cur.lat));
                end
            end
            if (in_resp) begin
                chk("resp_rdata", resp_rdata, cur.rdata);
                chk("resp_exception", {31'd0, resp_exception}, {31'd0, cur.exc});
            end
        end else begin
            in_resp = 1'b0;
        end
    end

    always @(negedge CLK) begin
        if (out_write_enable) begin
            if (wexp_q.size() == 0) begin
                chk("write_unexpected", out_write_address, 32'hFFFF_FFFF);
            end else begin
                wr_t w;
                w = wexp_q.pop_front();
                chk("write_latency", 32'(cyc - w.acc), 32'(w.lat));
                chk("write_addr", out_write_address, w.addr);
                chk("write_data", out_write_data, w.data);
            end
        end
    end

    task automatic issue(input logic st, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] e_rdata, input logic e_exc, input int e_lat,
                         input logic has_wr, input logic [31:0] e_waddr,
                         input logic [31:0] e_wdata, input int e_wlat);
        int acc;
        bit ok;
        ok = 1'b0;
        @(negedge CLK);
        for (int i = 0; i < 20 && !ok; i++) begin
            if (req_ready) ok = 1'b1;
            else @(negedge CLK);
        end
        chk("req_ready_wait", {31'd0, ok}, 32'd1);
        req_valid    = 1'b1;
        req_store    = st;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        @(posedge CLK);
        acc = cyc;
        exp_q.push_back('{rdata: e_rdata, exc: e_exc, lat: e_lat, acc: acc});
        if (has_wr) wexp_q.push_back('{addr: e_waddr, data: e_wdata, lat: e_wlat, acc: acc});
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge CLK);
            if (exp_q.size() == 0 && wexp_q.size() == 0 && !resp_valid && req_ready) done = 1'b1;
        end
        chk("completion_wait", {31'd0, done}, 32'd1);
    endtask

    task automatic load(input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                        input logic [31:0] e_rdata, input logic e_exc, input int e_lat);
        issue(1'b0, sz, uns, addr, 32'h0, e_rdata, e_exc, e_lat, 1'b0, 32'h0, 32'h0, 0);
        wait_idle();
    endtask

    initial begin
        int sw_rlat;
        int sw_wlat;
        bit seen;
`ifdef LSU_WORD_STORE_BYPASS_EN
        sw_rlat = 2;
        sw_wlat = 1;
`else
        sw_rlat = 3;
        sw_wlat = 2;
`endif
        for (int unsigned i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[32'h100 >> 2] = 32'h8899AABB;
        mem[32'h200 >> 2] = 32'h11223344;

        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_resp_exception", {31'd0, resp_exception}, 32'd0);
        chk("rst_write_enable", {31'd0, out_write_enable}, 32'd0);
        chk("rst_read_address", out_read_address, 32'h0);
        chk("rst_write_address", out_write_address, 32'h0);
        chk("rst_write_data", out_write_data, 32'h0);

        load(2'd0, 1'b0, 32'h101, 32'hFFFF_FFAA, 1'b0, 2);
        issue(1'b1, 2'd0, 1'b0, 32'h102, 32'h55, 32'h0, 1'b0, 3, 1'b1, 32'h100, 32'h8855AABB, 2);
        wait_idle();
        load(2'd1, 1'b0, 32'h103, 32'h0, 1'b1, 1);
        issue(1'b1, 2'd2, 1'b0, 32'h200, 32'hDEADBEEF, 32'h0, 1'b0, sw_rlat,
              1'b1, 32'h200, 32'hDEADBEEF, sw_wlat);
        wait_idle();

        rd_fault = 1'b1;
        issue(1'b1, 2'd1, 1'b0, 32'h100, 32'h1234, 32'h0, 1'b1, 2, 1'b0, 32'h0, 32'h0, 0);
        wait_idle();
        rd_fault = 1'b0;
        chk("mem_after_read_fault", mem[32'h100 >> 2], 32'h8855AABB);

        load(2'd1, 1'b1, 32'h102, 32'h0000_8855, 1'b0, 2);
        load(2'd1, 1'b0, 32'h102, 32'hFFFF_8855, 1'b0, 2);
        load(2'd0, 1'b1, 32'h103, 32'h0000_0088, 1'b0, 2);
        load(2'd2, 1'b0, 32'h200, 32'hDEADBEEF, 1'b0, 2);
        load(2'd3, 1'b0, 32'h200, 32'h0, 1'b1, 1);
        issue(1'b1, 2'd2, 1'b0, 32'h202, 32'h1, 32'h0, 1'b1, 1, 1'b0, 32'h0, 32'h0, 0);
        wait_idle();
        issue(1'b1, 2'd1, 1'b0, 32'h202, 32'hCAFE, 32'h0, 1'b0, 3, 1'b1, 32'h200, 32'hCAFEBEEF, 2);
        wait_idle();
        load(2'd2, 1'b0, 32'h200, 32'hCAFEBEEF, 1'b0, 2);

        wr_fault = 1'b1;
        issue(1'b1, 2'd0, 1'b0, 32'h201, 32'h12, 32'h0, 1'b1, 3, 1'b1, 32'h200, 32'hCAFE12EF, 2);
        wait_idle();
        wr_fault = 1'b0;
        load(2'd2, 1'b0, 32'h200, 32'hCAFEBEEF, 1'b0, 2);

        // Response held for three cycles with resp_ready low.
        resp_ready = 1'b0;
        issue(1'b0, 2'd0, 1'b1, 32'h100, 32'h0, 32'h0000_00BB, 1'b0, 2, 1'b0, 32'h0, 32'h0, 0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge CLK);
            if (resp_valid) seen = 1'b1;
        end
        chk("hold_resp_seen", {31'd0, seen}, 32'd1);
        repeat (3) @(negedge CLK);
        chk("hold_resp_valid", {31'd0, resp_valid}, 32'd1);
        resp_ready = 1'b1;
        wait_idle();

        // Reset while the sub-word store sits in WRITE.
        issue(1'b1, 2'd0, 1'b0, 32'h100, 32'h77, 32'h0, 1'b0, 3, 1'b0, 32'h0, 32'h0, 0);
        void'(exp_q.pop_back());
        @(posedge CLK);
        #1 RESET = 1'b1;
        @(negedge CLK);
        chk("rst_in_write_no_strobe", {31'd0, out_write_enable}, 32'd0);
        @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        chk("rst_in_write_idle", {31'd0, req_ready}, 32'd1);
        chk("rst_in_write_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_in_write_mem", mem[32'h100 >> 2], 32'h8855AABB);
        load(2'd2, 1'b0, 32'h100, 32'h8855AABB, 1'b0, 2);

        chk("resp_queue_drained", 32'(exp_q.size()), 32'd0);
        chk("write_queue_drained", 32'(wexp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
